// File: rtl/tluh_atomic_alu.sv
// TL-UH atomic unit: one ArithmeticData/LogicalData read-modify-write at a time.
// Returns the original memory beat; illegal requests and read errors are answered without a write.
module tluh_atomic_alu #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32,
  parameter int unsigned SW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [2:0]    req_opcode_i,
  input  logic [2:0]    req_param_i,
  input  logic [1:0]    req_size_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [DW/8-1:0] req_mask_i,
  input  logic [DW-1:0] req_data_i,
  input  logic [SW-1:0] req_source_i,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic [DW/8-1:0] mem_wmask_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_err_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_data_o,
  output logic [SW-1:0] rsp_source_o,
  output logic          rsp_error_o
);

  localparam int unsigned MW  = DW / 8;
  localparam int unsigned LMW = $clog2(MW);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RD_WAIT, S_WR, S_RSP} state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [2:0]      r_opcode;
  logic [2:0]      r_param;
  logic [1:0]      r_size;
  logic [AW-1:0]   r_addr;
  logic [MW-1:0]   r_mask;
  logic [DW-1:0]   r_data;
  logic [SW-1:0]   r_source;
  logic [DW-1:0]   r_old;
  logic [DW-1:0]   r_wdata;
  logic            r_err;

  int unsigned     w_nbytes;
  int unsigned     w_off_req;
  logic [MW-1:0]   w_exp_mask;
  logic            w_param_ok;
  logic            w_legal;

  int unsigned     w_shamt;
  int unsigned     w_nbits;
  logic [DW-1:0]   w_nmask;
  logic [DW-1:0]   w_top;
  logic [DW-1:0]   w_old_sh;
  logic [DW-1:0]   w_op_sh;
  logic            w_signed;
  logic [DW-1:0]   w_old_x;
  logic [DW-1:0]   w_op_x;
  logic [DW-1:0]   w_res;
  logic [DW-1:0]   w_new;

  // Request legality: opcode/param range, size, natural alignment and exact lane mask
  always_comb begin
    w_nbytes   = 32'(1) << req_size_i;
    w_off_req  = 32'(req_addr_i[LMW-1:0]);
    w_exp_mask = '0;
    for (int unsigned i = 0; i < MW; i++) begin
      w_exp_mask[i] = (i >= w_off_req) && (i < w_off_req + w_nbytes);
    end
    w_param_ok = ((req_opcode_i == 3'd2) && (req_param_i <= 3'd4)) ||
                 ((req_opcode_i == 3'd3) && (req_param_i <= 3'd3));
    w_legal    = w_param_ok && (32'(req_size_i) <= LMW) &&
                 ((w_off_req & (w_nbytes - 32'(1))) == 32'(0)) &&
                 (req_mask_i == w_exp_mask);
  end

  // Lane extraction, sign/zero extension and the atomic operation on the returned beat
  always_comb begin
    w_shamt  = 32'({r_addr[LMW-1:0], 3'b000});
    w_nbits  = 32'(8) << r_size;
    w_nmask  = {DW{1'b1}} >> (DW - w_nbits);
    w_top    = w_nmask ^ (w_nmask >> 1);
    w_old_sh = mem_rdata_i >> w_shamt;
    w_op_sh  = r_data >> w_shamt;
    w_signed = (r_opcode == 3'd2) && (r_param <= 3'd1);
    w_old_x  = (w_old_sh & w_nmask) |
               ((w_signed && |(w_old_sh & w_top)) ? ~w_nmask : '0);
    w_op_x   = (w_op_sh & w_nmask) |
               ((w_signed && |(w_op_sh & w_top)) ? ~w_nmask : '0);
    w_res    = w_old_x;
    if (r_opcode == 3'd2) begin
      case (r_param)
        3'd0:    w_res = ($signed(w_op_x) < $signed(w_old_x)) ? w_op_x : w_old_x;
        3'd1:    w_res = ($signed(w_op_x) > $signed(w_old_x)) ? w_op_x : w_old_x;
        3'd2:    w_res = (w_op_x < w_old_x) ? w_op_x : w_old_x;
        3'd3:    w_res = (w_op_x > w_old_x) ? w_op_x : w_old_x;
        3'd4:    w_res = w_old_x + w_op_x;
        default: w_res = w_old_x;
      endcase
    end else begin
      case (r_param)
        3'd0:    w_res = w_old_x ^ w_op_x;
        3'd1:    w_res = w_old_x | w_op_x;
        3'd2:    w_res = w_old_x & w_op_x;
        default: w_res = w_op_x;
      endcase
    end
    w_new = (mem_rdata_i & ~(w_nmask << w_shamt)) | ((w_res & w_nmask) << w_shamt);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:    if (req_valid_i)  w_state_nx = w_legal ? S_RD : S_RSP;
      S_RD:      if (mem_gnt_i)    w_state_nx = S_RD_WAIT;
      S_RD_WAIT: if (mem_rvalid_i) w_state_nx = mem_err_i ? S_RSP : S_WR;
      S_WR:      if (mem_gnt_i)    w_state_nx = S_RSP;
      S_RSP:     if (rsp_ready_i)  w_state_nx = S_IDLE;
      default:   w_state_nx = S_IDLE;
    endcase
  end

  // Transaction context; r_old stays zero on any error so the response beat reads as zero
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_opcode <= '0;
      r_param  <= '0;
      r_size   <= '0;
      r_addr   <= '0;
      r_mask   <= '0;
      r_data   <= '0;
      r_source <= '0;
      r_old    <= '0;
      r_wdata  <= '0;
      r_err    <= 1'b0;
    end else if ((r_state == S_IDLE) && req_valid_i) begin
      r_opcode <= req_opcode_i;
      r_param  <= req_param_i;
      r_size   <= req_size_i;
      r_addr   <= req_addr_i;
      r_mask   <= req_mask_i;
      r_data   <= req_data_i;
      r_source <= req_source_i;
      r_old    <= '0;
      r_wdata  <= '0;
      r_err    <= ~w_legal;
    end else if ((r_state == S_RD_WAIT) && mem_rvalid_i) begin
      if (mem_err_i) begin
        r_err <= 1'b1;
      end else begin
        r_old   <= mem_rdata_i;
        r_wdata <= w_new;
      end
    end
  end

  // Outputs decoded from state and held context registers only
  always_comb begin
    req_ready_o  = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_wmask_o  = '0;
    rsp_valid_o  = 1'b0;
    rsp_data_o   = '0;
    rsp_source_o = '0;
    rsp_error_o  = 1'b0;
    case (r_state)
      S_IDLE: req_ready_o = 1'b1;
      S_RD: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {r_addr[AW-1:LMW], LMW'(0)};
      end
      S_WR: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {r_addr[AW-1:LMW], LMW'(0)};
        mem_wdata_o = r_wdata;
        mem_wmask_o = r_mask;
      end
      S_RSP: begin
        rsp_valid_o  = 1'b1;
        rsp_data_o   = r_old;
        rsp_source_o = r_source;
        rsp_error_o  = r_err;
      end
      default: ;
    endcase
  end

endmodule
